// File: rtl/bcd_key_counter.sv
// rtl/bcd_key_counter.sv - debounced inc/dec/clr keys driving a BCD counter on a scanned 7-seg display (option: LEADING_ZERO_BLANK_EN)
module bcd_key_counter #(
  parameter int NUM_DIGITS = 8,
  parameter int DEB_DELAY  = 250,
  parameter int SCAN_COUNT = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    inc_key_i,
  input  logic                    dec_key_i,
  input  logic                    clr_key_i,
  output logic [4*NUM_DIGITS-1:0] count_o,
  output logic                    wrap_o,
  output logic                    dspl_a,
  output logic                    dspl_b,
  output logic                    dspl_c,
  output logic                    dspl_d,
  output logic                    dspl_e,
  output logic                    dspl_f,
  output logic                    dspl_g,
  output logic                    dspl_p,
  output logic [7:0]              dspl_an
);

  localparam int DW = $clog2(DEB_DELAY);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_DELAY - 1);
  localparam int PW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_COUNT - 1);
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

  // key order in all 3-bit vectors: [0]=inc, [1]=dec, [2]=clr
  logic [2:0]    keys;
  logic [2:0]    sync1, sync2, stable, stable_d, press;
  logic [DW-1:0] deb_cnt [3];

  logic [4*NUM_DIGITS-1:0] count_q, inc_val, dec_val;
  logic                    wrap_q, inc_wrap, dec_wrap;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [3:0]    cur_digit;
  logic [6:0]    seg_on;
  logic [6:0]    seg_n;

  assign keys  = {clr_key_i, dec_key_i, inc_key_i};
  assign press = stable & ~stable_d;

  // two-stage synchroniser for the raw pushbuttons
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // debouncers: accept a new level only after DEB_DELAY cycles of disagreement
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable   <= '0;
      stable_d <= '0;
      for (int k = 0; k < 3; k++) deb_cnt[k] <= '0;
    end else begin
      stable_d <= stable;
      for (int k = 0; k < 3; k++) begin
        if (sync2[k] == stable[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_LAST) begin
          stable[k]  <= ~stable[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  // BCD +1 and -1 candidates with decimal carry/borrow rippling up the digits
  always_comb begin
    logic       carry, borrow;
    logic [3:0] d;
    inc_val  = count_q;
    dec_val  = count_q;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (d == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    inc_wrap = carry;
    dec_wrap = borrow;
  end

  // counter update: clear wins, simultaneous inc+dec cancel
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (press[2]) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (press[0] && press[1]) begin
      count_q <= count_q;
    end else if (press[0]) begin
      count_q <= inc_val;
      if (inc_wrap) wrap_q <= 1'b1;
    end else if (press[1]) begin
      count_q <= dec_val;
      if (dec_wrap) wrap_q <= 1'b1;
    end
  end

  // scan prescaler and digit index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // select and decode the indexed digit (segment bits {a..g}, 1 = lit)
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (3'(i) == idx) cur_digit = count_q[4*i +: 4];
    end
    case (cur_digit)
      4'd0:    seg_on = 7'b1111110;
      4'd1:    seg_on = 7'b0110000;
      4'd2:    seg_on = 7'b1101101;
      4'd3:    seg_on = 7'b1111001;
      4'd4:    seg_on = 7'b0110011;
      4'd5:    seg_on = 7'b1011011;
      4'd6:    seg_on = 7'b1011111;
      4'd7:    seg_on = 7'b1110000;
      4'd8:    seg_on = 7'b1111111;
      4'd9:    seg_on = 7'b1111011;
      default: seg_on = 7'b0000000;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic [2:0] top_nz;
      top_nz = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (count_q[4*i +: 4] != 4'd0) top_nz = 3'(i);
      end
      if (idx > top_nz) seg_on = 7'b0000000;
    end
`endif
  end

  // registered display drivers so pins never glitch during index changes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dspl_an <= 8'hFE;
      seg_n   <= 7'b0000001;
      dspl_p  <= 1'b1;
    end else begin
      dspl_an <= ({1'b0, idx} <= {1'b0, IDX_LAST}) ? ~(8'b1 << idx) : 8'hFF;
      seg_n   <= ~seg_on;
      dspl_p  <= ~((idx == 3'd0) && wrap_q);
    end
  end

  assign {dspl_a, dspl_b, dspl_c, dspl_d, dspl_e, dspl_f, dspl_g} = seg_n;
  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_bcd_key_counter.sv
// tb/tb_bcd_key_counter.sv - directed self-checking bench for bcd_key_counter
module tb_bcd_key_counter;
  localparam int ND  = 4;
  localparam int DEB = 250;
  localparam int SC  = 5;

  logic          clk = 1'b0;
  logic          rst_n, inc, dec, clr;
  logic [4*ND-1:0] count;
  logic          wrap, sa, sb, sc, sd, se, sf, sg, sp;
  logic [7:0]    an;
  logic [6:0]    segs;

  int checks = 0;
  int fails  = 0;

  bcd_key_counter #(.NUM_DIGITS(ND), .DEB_DELAY(DEB), .SCAN_COUNT(SC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .inc_key_i(inc), .dec_key_i(dec), .clr_key_i(clr),
    .count_o(count), .wrap_o(wrap),
    .dspl_a(sa), .dspl_b(sb), .dspl_c(sc), .dspl_d(sd), .dspl_e(se), .dspl_f(sf),
    .dspl_g(sg), .dspl_p(sp), .dspl_an(an)
  );

  assign segs = {sa, sb, sc, sd, se, sf, sg};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] which);
    {clr, dec, inc} = which;
    step(DEB + 4);
    {clr, dec, inc} = 3'b000;
    step(DEB + 4);
  endtask

  task automatic wait_an(input logic [7:0] v, input string tag);
    int n;
    n = 0;
    while (an !== v && n < 50) begin
      step(1);
      n++;
    end
    chk(tag, {24'b0, an}, {24'b0, v});
  endtask

  task automatic bounce();
    int lens [5];
    lens = '{1, 3, 8, 2, 5};
    foreach (lens[i]) begin
      inc = 1'b1;
      step(lens[i]);
      inc = 1'b0;
      step(4);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inc = 1'b0; dec = 1'b0; clr = 1'b0;
    step(3);
    chk("rst_count", {16'b0, count}, 32'h0);
    chk("rst_wrap", {31'b0, wrap}, 32'h0);
    chk("rst_an", {24'b0, an}, 32'hFE);
    chk("rst_segs", {25'b0, segs}, 32'h01);
    chk("rst_p", {31'b0, sp}, 32'h1);

    rst_n = 1'b1;
    step(5);  chk("scan_e5", {24'b0, an}, 32'hFE);
    step(1);  chk("scan_e6", {24'b0, an}, 32'hFD);
    step(5);  chk("scan_e11", {24'b0, an}, 32'hFB);
    step(5);  chk("scan_e16", {24'b0, an}, 32'hF7);
    step(5);  chk("scan_e21", {24'b0, an}, 32'hFE);

    bounce();
    step(5);
    inc = 1'b1;
    step(DEB + 2); chk("latency_before", {16'b0, count}, 32'h0000);
    step(1);       chk("latency_after", {16'b0, count}, 32'h0001);
    step(2000);    chk("held_no_repeat", {16'b0, count}, 32'h0001);
    inc = 1'b0;
    step(DEB + 4); chk("release_no_pulse", {16'b0, count}, 32'h0001);

    bounce();
    step(DEB + 4); chk("bounce_only", {16'b0, count}, 32'h0001);
    inc = 1'b1; step(DEB - 1); inc = 1'b0;
    step(DEB + 4); chk("glitch_short", {16'b0, count}, 32'h0001);
    inc = 1'b1; step(DEB); inc = 1'b0;
    step(DEB + 4); chk("glitch_exact", {16'b0, count}, 32'h0002);

    press(3'b100); chk("clr_to_zero", {16'b0, count}, 32'h0000);
    repeat (9) press(3'b001);
    chk("inc_9", {16'b0, count}, 32'h0009);
    press(3'b001);
    chk("inc_10_carry", {16'b0, count}, 32'h0010);

    press(3'b100);
    press(3'b010);
    chk("dec_wrap_val", {16'b0, count}, 32'h9999);
    chk("dec_wrap_flag", {31'b0, wrap}, 32'h1);
    wait_an(8'hFE, "wait_fe_p");
    chk("p_low_idx0", {31'b0, sp}, 32'h0);
    wait_an(8'hFD, "wait_fd_p");
    chk("p_high_idx1", {31'b0, sp}, 32'h1);
    press(3'b001);
    chk("inc_wrap_val", {16'b0, count}, 32'h0000);
    chk("wrap_sticky", {31'b0, wrap}, 32'h1);
    press(3'b100);
    chk("clr_wrap", {31'b0, wrap}, 32'h0);
    wait_an(8'hFE, "wait_fe_p2");
    chk("p_high_nowrap", {31'b0, sp}, 32'h1);

    repeat (42) press(3'b001);
    chk("inc_42", {16'b0, count}, 32'h0042);
    press(3'b011);
    chk("inc_dec_cancel", {16'b0, count}, 32'h0042);
    press(3'b111);
    chk("all_three_clr", {16'b0, count}, 32'h0000);

    repeat (7) press(3'b001);
    chk("inc_7", {16'b0, count}, 32'h0007);
    wait_an(8'hFE, "wait_fe_seg");
    chk("seg_digit0_7", {25'b0, segs}, 32'h0F);
    wait_an(8'hFD, "wait_fd_seg");
`ifdef LEADING_ZERO_BLANK_EN
    chk("seg_digit1", {25'b0, segs}, 32'h7F);
`else
    chk("seg_digit1", {25'b0, segs}, 32'h01);
`endif
    wait_an(8'hF7, "wait_f7_seg");
`ifdef LEADING_ZERO_BLANK_EN
    chk("seg_digit3", {25'b0, segs}, 32'h7F);
`else
    chk("seg_digit3", {25'b0, segs}, 32'h01);
`endif

    inc = 1'b1;
    step(100);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", {16'b0, count}, 32'h0000);
    chk("async_rst_an", {24'b0, an}, 32'hFE);
    step(2);
    rst_n = 1'b1;
    step(DEB + 2); chk("rst_held_before", {16'b0, count}, 32'h0000);
    step(1);       chk("rst_held_after", {16'b0, count}, 32'h0001);
    inc = 1'b0;
    step(DEB + 4);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
